// File: rtl/blind_rotation_ctrl.sv
// Blind-rotation sequencer: clears the rotation datapath, streams one polynomial from the
// source BRAM through it and writes the rotated words back into the destination BRAM.
module blind_rotation_ctrl #(
  parameter int BITMASK_SIZE      = 32,
  parameter int BRAM_MAX_SIZE     = 100,
  parameter int DATA_SIZE         = 2,
  parameter int NUM_WORDS         = BRAM_MAX_SIZE,
  parameter int BRAM_READ_LATENCY = 2,
  parameter int WATCHDOG_SLACK    = 16,
  localparam int AW               = $clog2(BRAM_MAX_SIZE)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic [BITMASK_SIZE-1:0] rotation_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    error_out,
  output logic [AW-1:0]           rd_addr_out,
  input  logic [DATA_SIZE-1:0]    rd_data_in,
  output logic                    rot_rst_out,
  output logic [BITMASK_SIZE-1:0] rot_amount_out,
  output logic                    rot_valid_out,
  output logic [AW-1:0]           rot_addr_out,
  output logic [DATA_SIZE-1:0]    rot_data_out,
  input  logic                    rot_valid_in,
  input  logic [AW-1:0]           rot_addr_in,
  input  logic [DATA_SIZE-1:0]    rot_data_in,
  output logic                    wr_en_out,
  output logic [AW-1:0]           wr_addr_out,
  output logic [DATA_SIZE-1:0]    wr_data_out,
  output logic [2:0]              dbg_state_out
);

  localparam int CW     = AW + 1;
  localparam int LAT    = BRAM_READ_LATENCY;
  localparam int WD_MAX = BRAM_READ_LATENCY + WATCHDOG_SLACK + 2;
  localparam int WDW    = $clog2(WD_MAX + 1);
  localparam logic [CW-1:0]  NW       = CW'(NUM_WORDS);
  localparam logic [CW-1:0]  NW_M1    = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(WD_MAX);
  localparam logic [WDW-1:0] WD_ONE   = WDW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]           wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]           wr_pend;
  logic [WDW-1:0]          wd_q, wd_d;
  logic [BITMASK_SIZE-1:0] amount_q, amount_d;
  logic                    odd_q, odd_d;
  logic                    err_q, err_d;
  logic                    rd_issue;
  logic [AW-1:0]           rd_addr;
  logic [CW-1:0]           last_rd;
  logic [LAT-1:0]          pipe_v_q;
  logic [AW-1:0]           pipe_a_q [LAT];
  logic                    accept;
  logic                    wr_en_q, wr_en_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [DATA_SIZE-1:0]    wr_data_q, wr_data_d;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      wd_q      <= '0;
      amount_q  <= '0;
      odd_q     <= 1'b0;
      err_q     <= 1'b0;
      pipe_v_q  <= '0;
      for (int i = 0; i < LAT; i++) pipe_a_q[i] <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wd_q      <= wd_d;
      amount_q  <= amount_d;
      odd_q     <= odd_d;
      err_q     <= err_d;
      pipe_v_q[0] <= rd_issue;
      pipe_a_q[0] <= rd_addr;
      for (int i = 1; i < LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_a_q[i] <= pipe_a_q[i-1];
      end
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Odd rotations issue one extra read (address 0) so the datapath can emit every word.
  assign last_rd = odd_q ? NW : NW_M1;

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_en_q ? (wr_cnt_q + CNT_ONE) : wr_cnt_q;
    wd_d     = wd_q;
    amount_d = amount_q;
    odd_d    = odd_q;
    err_d    = err_q;
    rd_issue = 1'b0;
    rd_addr  = '0;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          amount_d = rotation_in;
          odd_d    = rotation_in[0];
          err_d    = 1'b0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        rd_cnt_d = '0;
        wr_cnt_d = '0;
        state_d  = S_READ;
      end
      S_READ: begin
        rd_issue = 1'b1;
        rd_addr  = (rd_cnt_q == NW) ? '0 : rd_cnt_q[AW-1:0];
        rd_cnt_d = rd_cnt_q + CNT_ONE;
        if (rd_cnt_q == last_rd) begin
          state_d = S_DRAIN;
          wd_d    = '0;
        end
      end
      S_DRAIN: begin
        wd_d = wd_q + WD_ONE;
        if (wr_cnt_q == NW) begin
          state_d = S_DONE;
        end else if (wd_d == WD_LIMIT) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Valid-only streams, no ready: the datapath takes a word on every cycle rot_valid_out is
  // high, and this block takes a word on every cycle rot_valid_in is high (surplus dropped).
  assign wr_pend = wr_cnt_q + {{AW{1'b0}}, wr_en_q};
  assign accept  = rot_valid_in && ((state_q == S_READ) || (state_q == S_DRAIN)) && (wr_pend < NW);

  always_comb begin
    wr_en_d   = accept;
    wr_addr_d = '0;
    wr_data_d = '0;
    if (accept) begin
      wr_addr_d = rot_addr_in;
      wr_data_d = rot_data_in;
    end
  end

  assign busy_out       = (state_q != S_IDLE);
  assign done_out       = (state_q == S_DONE);
  assign error_out      = (state_q == S_DONE) && err_q;
  assign rd_addr_out    = rd_addr;
  assign rot_rst_out    = !rst_in || (state_q == S_CLEAR);
  assign rot_amount_out = amount_q;
  assign rot_valid_out  = pipe_v_q[LAT-1];
  assign rot_addr_out   = pipe_v_q[LAT-1] ? pipe_a_q[LAT-1] : '0;
  assign rot_data_out   = pipe_v_q[LAT-1] ? rd_data_in : '0;
  assign wr_en_out      = wr_en_q;
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;
  assign dbg_state_out  = state_q;

endmodule

// File: tb/tb_blind_rotation_ctrl.sv
// Directed bench for blind_rotation_ctrl: BRAM and datapath responders, per-cycle logs of one
// job, and hand-computed cycle/data expectations.
module tb_blind_rotation_ctrl;
  localparam int BW    = 32;
  localparam int BMS   = 100;
  localparam int DW    = 2;
  localparam int NW    = 4;
  localparam int LAT   = 2;
  localparam int SLACK = 16;
  localparam int AW    = $clog2(BMS);

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [BW-1:0] rotation_in;
  logic          busy_out, done_out, error_out;
  logic [AW-1:0] rd_addr_out;
  logic [DW-1:0] rd_data_in;
  logic          rot_rst_out;
  logic [BW-1:0] rot_amount_out;
  logic          rot_valid_out;
  logic [AW-1:0] rot_addr_out;
  logic [DW-1:0] rot_data_out;
  logic          rot_valid_in = 1'b0;
  logic [AW-1:0] rot_addr_in = '0;
  logic [DW-1:0] rot_data_in = '0;
  logic          wr_en_out;
  logic [AW-1:0] wr_addr_out;
  logic [DW-1:0] wr_data_out;
  logic [2:0]    dbg_state_out;

  blind_rotation_ctrl #(
    .BITMASK_SIZE(BW), .BRAM_MAX_SIZE(BMS), .DATA_SIZE(DW), .NUM_WORDS(NW),
    .BRAM_READ_LATENCY(LAT), .WATCHDOG_SLACK(SLACK)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .rotation_in(rotation_in),
    .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
    .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
    .rot_rst_out(rot_rst_out), .rot_amount_out(rot_amount_out),
    .rot_valid_out(rot_valid_out), .rot_addr_out(rot_addr_out), .rot_data_out(rot_data_out),
    .rot_valid_in(rot_valid_in), .rot_addr_in(rot_addr_in), .rot_data_in(rot_data_in),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .dbg_state_out(dbg_state_out)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- source BRAM model (2-cycle read latency) ----------------
  logic [AW-1:0] bram_a1 = '0;
  logic [AW-1:0] bram_a2 = '0;
  logic [DW-1:0] src_mem [128];
  always @(posedge clk_in) begin
    bram_a1 <= rd_addr_out;
    bram_a2 <= bram_a1;
  end
  assign rd_data_in = src_mem[bram_a2];

  // ---------------- datapath model ----------------
  // mode 0: echo with rotated address, 1 cycle later; 1: silent; 2: echo plus two surplus words
  int dp_mode = 0;
  int dp_hold = 0;
  always @(posedge clk_in) begin
    if (dp_mode == 1) begin
      rot_valid_in <= 1'b0;
    end else if (rot_valid_out) begin
      rot_valid_in <= 1'b1;
      rot_addr_in  <= AW'((int'(rot_addr_out) + int'(rot_amount_out)) % NW);
      rot_data_in  <= rot_data_out;
      dp_hold      <= (dp_mode == 2) ? 2 : 0;
    end else if (dp_hold > 0) begin
      rot_valid_in <= 1'b1;
      rot_addr_in  <= '0;
      rot_data_in  <= 2'b11;
      dp_hold      <= dp_hold - 1;
    end else begin
      rot_valid_in <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [AW+DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Destination word i of a job: address (i + rot) mod NW carrying source word i = (i+1) mod NW.
  task automatic push_exp(input int rot, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({AW'((i + rot) % NW), DW'((i + 1) % NW)});
  endtask

  // ---------------- per-job logs ----------------
  logic          log_rst  [64];
  logic          log_rv   [64];
  logic          log_busy [64];
  logic [AW-1:0] log_rda  [64];
  logic [AW-1:0] log_ra   [64];
  logic [DW-1:0] log_rdat [64];
  logic [BW-1:0] log_amt  [64];
  int            done_c, n_done, n_wr, wr_first, wr_last;
  logic          err_at_done;

  // Starts a job at the current negedge (cycle 0) and logs cycles 1.. at each negedge.
  task automatic run_job(input logic [BW-1:0] rot, input int mode, input int busy_start_c,
                         input int rst_c);
    int c;
    int stop_c;
    logic [AW+DW-1:0] exp_w;
    for (int i = 0; i < 64; i++) begin
      log_rst[i] = 1'b0; log_rv[i] = 1'b0; log_busy[i] = 1'b0;
      log_rda[i] = '0; log_ra[i] = '0; log_rdat[i] = '0; log_amt[i] = '0;
    end
    done_c = -1; n_done = 0; n_wr = 0; wr_first = -1; wr_last = -1; err_at_done = 1'b0;
    dp_mode     = mode;
    start_in    = 1'b1;
    rotation_in = rot;
    c = 0;
    stop_c = 60;
    while (c < stop_c) begin
      @(negedge clk_in);
      c++;
      log_rst[c]  = rot_rst_out;
      log_rv[c]   = rot_valid_out;
      log_busy[c] = busy_out;
      log_rda[c]  = rd_addr_out;
      log_ra[c]   = rot_addr_out;
      log_rdat[c] = rot_data_out;
      log_amt[c]  = rot_amount_out;
      if (wr_en_out) begin
        n_wr++;
        if (wr_first < 0) wr_first = c;
        wr_last = c;
        if (exp_q.size() == 0) begin
          check("wr_unexpected_en", {63'd0, wr_en_out}, 64'd0);
        end else begin
          exp_w = exp_q.pop_front();
          check("wr_word", {wr_addr_out, wr_data_out}, exp_w);
        end
      end
      if (done_out) begin
        n_done++;
        if (done_c < 0) begin
          done_c = c;
          err_at_done = error_out;
          stop_c = c + 3;
        end
      end
      if (c == 1) start_in = 1'b0;
      if (busy_start_c > 0 && c == busy_start_c) begin
        start_in = 1'b1;
        rotation_in = 5;
      end
      if (busy_start_c > 0 && c == busy_start_c + 1) start_in = 1'b0;
      if (rst_c > 0 && c == rst_c) rst_in = 1'b0;
      if (rst_c > 0 && c == rst_c + 1) begin
        rst_in = 1'b1;
        stop_c = c + 6;
      end
    end
    check("wr_missing", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 128; i++) src_mem[i] = DW'((i + 1) % NW);
    rst_in = 1'b0;
    start_in = 1'b0;
    rotation_in = '0;
    repeat (3) @(negedge clk_in);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_error", error_out, 0);
    check("rst_wr_en", wr_en_out, 0);
    check("rst_rd_addr", rd_addr_out, 0);
    check("rst_rot_valid", rot_valid_out, 0);
    check("rst_rot_rst", rot_rst_out, 1);
    check("rst_amount", rot_amount_out, 0);
    rst_in = 1'b1;
    @(negedge clk_in);
    check("rel_rot_rst", rot_rst_out, 0);
    check("rel_busy", busy_out, 0);

    // 1: even job, rotation 2
    push_exp(2, 4);
    run_job(2, 0, 0, 0);
    check("t1_clear", log_rst[1], 1);
    check("t1_clear_len", log_rst[2], 0);
    for (int i = 0; i < 4; i++) begin
      check("t1_rd_addr", log_rda[2+i], i);
      check("t1_rv", log_rv[4+i], 1);
      check("t1_rv_addr", log_ra[4+i], i);
      check("t1_rv_data", log_rdat[4+i], (i + 1) % NW);
    end
    check("t1_rv_before", log_rv[3], 0);
    check("t1_rv_after", log_rv[8], 0);
    check("t1_amount", log_amt[5], 2);
    check("t1_wr_first", wr_first, 6);
    check("t1_wr_last", wr_last, 9);
    check("t1_n_wr", n_wr, 4);
    check("t1_done_cycle", done_c, 11);
    check("t1_n_done", n_done, 1);
    check("t1_error", err_at_done, 0);
    check("t1_busy_done", log_busy[11], 1);
    check("t1_busy_after", log_busy[12], 0);

    // 2: odd job, rotation 3: reads 0,1,2,3,0
    push_exp(3, 4);
    run_job(3, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("t2_rd_addr", log_rda[2+i], i % NW);
      check("t2_rv", log_rv[4+i], 1);
    end
    check("t2_rv_after", log_rv[9], 0);
    check("t2_refeed_addr", log_ra[8], 0);
    check("t2_refeed_data", log_rdat[8], 1);
    check("t2_n_wr", n_wr, 4);
    check("t2_n_done", n_done, 1);
    check("t2_done_cycle", done_c, 11);

    // 3: start while busy is ignored
    push_exp(2, 4);
    run_job(2, 0, 3, 0);
    check("t3_amount_mid", log_amt[5], 2);
    check("t3_amount_done", log_amt[11], 2);
    check("t3_n_done", n_done, 1);
    check("t3_idle_1", log_busy[12], 0);
    check("t3_idle_2", log_busy[13], 0);

    // 4: reset during DRAIN, then a normal job
    push_exp(2, 2);
    run_job(2, 0, 0, 7);
    check("t4_busy", log_busy[8], 0);
    check("t4_rot_rst", log_rst[8], 1);
    check("t4_n_wr", n_wr, 2);
    check("t4_n_done", n_done, 0);
    check("t4_idle_later", log_busy[12], 0);
    push_exp(2, 4);
    run_job(2, 0, 0, 0);
    check("t4b_done_cycle", done_c, 11);
    check("t4b_n_wr", n_wr, 4);
    check("t4b_error", err_at_done, 0);

    // 5: watchdog, datapath silent; DRAIN entered at cycle 6
    run_job(2, 1, 0, 0);
    check("t5_done_cycle", done_c, 6 + LAT + SLACK + 2);
    check("t5_error", err_at_done, 1);
    check("t5_n_done", n_done, 1);
    check("t5_n_wr", n_wr, 0);
    check("t5_busy_before", log_busy[25], 1);

    // 6: datapath emits 6 valids
    push_exp(2, 4);
    run_job(2, 2, 0, 0);
    check("t6_n_wr", n_wr, 4);
    check("t6_wr_last", wr_last, 9);
    check("t6_n_done", n_done, 1);
    check("t6_done_cycle", done_c, 11);
    check("t6_error", err_at_done, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/blind_rotation_ctrl.md
Name: blind_rotation_ctrl

Overview:
Sequencer for the blind-rotation datapath. On `start_in` it performs these steps for one polynomial of `NUM_WORDS` words:
- clears the datapath;
- streams the polynomial out of the source BRAM into the datapath (one word per cycle);
- writes the datapath's rotated words into the destination BRAM;
- reports completion.
For odd rotations it re-feeds word 0 so that the datapath emits all `NUM_WORDS` outputs. It sits between the coefficient BRAMs and the rotation datapath in the TFHE bootstrapping path.

Parameters:
- `BITMASK_SIZE`, 32, width of the rotation amount.
- `BRAM_MAX_SIZE`, 100, BRAM depth; address width `AW = $clog2(BRAM_MAX_SIZE)`.
- `DATA_SIZE`, 2, word width. Must be even.
- `NUM_WORDS`, `BRAM_MAX_SIZE`, words per job. Range 2..`BRAM_MAX_SIZE`.
- `BRAM_READ_LATENCY`, 2, cycles from `rd_addr_out` to valid `rd_data_in`.
- `WATCHDOG_SLACK`, 16, extra `DRAIN` cycles allowed before the job aborts.

Ports:
- `clk_in`, input, 1, system clock.
- `rst_in`, input, 1, synchronous reset, active-low.
- `start_in`, input, 1, job request. Sampled only in `IDLE`.
- `rotation_in`, input, `BITMASK_SIZE`, rotation amount. Latched on an accepted start.
- `busy_out`, output, 1, high whenever the FSM is not in `IDLE`.
- `done_out`, output, 1, one-cycle completion pulse.
- `error_out`, output, 1, one-cycle pulse coincident with `done_out` when the watchdog fired.
- `rd_addr_out`, output, `AW`, source BRAM read address.
- `rd_data_in`, input, `DATA_SIZE`, source BRAM read data.
- `rot_rst_out`, output, 1, active-high clear to the datapath.
- `rot_amount_out`, output, `BITMASK_SIZE`, latched rotation amount. Held for the whole job.
- `rot_valid_out`, output, 1, datapath input valid.
- `rot_addr_out`, output, `AW`, datapath input address.
- `rot_data_out`, output, `DATA_SIZE`, datapath input data.
- `rot_valid_in`, input, 1, datapath output valid.
- `rot_addr_in`, input, `AW`, datapath output address.
- `rot_data_in`, input, `DATA_SIZE`, datapath output data.
- `wr_en_out`, output, 1, destination BRAM write enable.
- `wr_addr_out`, output, `AW`, destination BRAM write address.
- `wr_data_out`, output, `DATA_SIZE`, destination BRAM write data.

Behaviour:
- Reset (`rst_in` == 0 at a clock edge):
  - FSM goes to `IDLE`; all counters and the read pipeline clear.
  - Every output is 0, except `rot_rst_out`, which is 1 while reset is held.
  - Reset mid-job abandons the job: no `done_out` pulse, no further `wr_en_out`.
- FSM states: `IDLE` -> `CLEAR` -> `READ` -> `DRAIN` -> `DONE` -> `IDLE`.
- `IDLE`:
  - `start_in` == 1 latches `rotation_in` into `rot_amount_out` and the parity `odd = rotation_in[0]`, then moves to `CLEAR`.
  - `start_in` in any other state is ignored. There is no queuing.
- `CLEAR`:
  - Lasts exactly 1 cycle with `rot_rst_out` = 1.
  - Zeroes the read counter and the write counter.
  - Moves to `READ`.
- `READ`:
  - Issues one read per cycle.
  - Addresses 0..`NUM_WORDS`-1.
  - If `odd`, one extra read of address 0 follows, for `NUM_WORDS`+1 reads total.
  - Moves to `DRAIN` the cycle after the last read is issued.
  - `rd_addr_out` is 0 outside `READ`.
- Read pipeline:
  - A valid/address shift register of depth `BRAM_READ_LATENCY` tracks outstanding reads.
  - `rot_valid_out`, `rot_addr_out` and `rot_data_out` (= `rd_data_in`) are presented exactly `BRAM_READ_LATENCY` cycles after the matching read.
  - These signals are combinational from the pipeline head and `rd_data_in`.
  - The re-fed word carries address 0.
- Write path:
  - Registered, latency 1: `wr_en_out`, `wr_addr_out` and `wr_data_out` follow `rot_valid_in`, `rot_addr_in` and `rot_data_in` by one cycle.
  - Addresses pass through unmodified.
  - The write counter increments on each `wr_en_out`.
  - Only the first `NUM_WORDS` valid outputs are written; any surplus is dropped.
- `DRAIN`:
  - Exits to `DONE` on the cycle after the write counter reaches `NUM_WORDS`.
  - Watchdog counter clears on entry to `DRAIN`.
  - If the watchdog reaches `BRAM_READ_LATENCY` + `WATCHDOG_SLACK` + 2 first, the FSM moves to `DONE` with the error flag set.
- `DONE`:
  - Lasts 1 cycle with `done_out` = 1, and `error_out` = error flag.
  - `busy_out` is still 1 in this cycle.
  - Returns to `IDLE`; `start_in` is accepted again from the next cycle.
- Widths:
  - Counters are `AW`+1 bits, so that `NUM_WORDS` == `BRAM_MAX_SIZE` is reachable without wrap.
  - The address counter wraps only on the odd re-feed back to 0.
- Rotation of 0 follows the even path; the output is a pure copy.
- Simultaneous `start_in` and `done_out`: the start is ignored, because the FSM is in `DONE`, not `IDLE`.

Test Plan:
1. Even job: `NUM_WORDS`=4, `BRAM_READ_LATENCY`=2, `rotation_in`=2, start at cycle 0.
   - `CLEAR` at cycle 1; reads 0..3 at cycles 2-5; `rot_valid_out` high at cycles 4-7.
   - Datapath echoes with 1-cycle latency; `wr_en_out` high at cycles 6-9; `done_out` at cycle 11; `error_out`=0.
2. Odd job: `NUM_WORDS`=4, `rotation_in`=3.
   - 5 reads with address sequence 0,1,2,3,0; `rot_valid_out` high for 5 cycles.
   - Exactly 4 writes; `done_out` pulses once.
3. Start while busy: assert `start_in` with `rotation_in`=5 during `READ` of a `rotation_in`=2 job.
   - `rot_amount_out` stays 2; a single `done_out`; no second job starts.
4. Reset mid-job: drive `rst_in`=0 during `DRAIN`.
   - Next cycle: `busy_out`=0, `wr_en_out`=0, `rot_rst_out`=1, no `done_out`.
   - A new start after release completes normally.
5. Watchdog: datapath never asserts `rot_valid_in`.
   - `done_out`=1 and `error_out`=1 exactly `BRAM_READ_LATENCY`+`WATCHDOG_SLACK`+2 cycles after entering `DRAIN`.
6. Surplus outputs: datapath emits 6 valids on a `NUM_WORDS`=4 job.
   - Only the first 4 are written; `done_out` fires once.
